exu_alu_seq: RTL and testbench
==============================

// Module: exu_alu_seq
// PURPOSE
//  Execution ALU behind the EXU operand selector; consumes alu_a/alu_b/alu_funct and returns alu_result.
//  Valid/ready handshake on both sides; logic ops complete in one registered cycle, shifts iterate.
//  Sits between the EXU operand mux and writeback/branch/LSU address logic.
// PARAMETERS
//  ISA_WIDTH     32   operand/result width (default from `ISA_WIDTH)
//  SHCNT_WIDTH   5    shift-amount width, $clog2(ISA_WIDTH)
// PORTS
//  clk            in   1                  single clock, all logic on posedge
//  rst            in   1                  synchronous, active-high reset
//  alu_a          in   ISA_WIDTH          operand A
//  alu_b          in   ISA_WIDTH          operand B; shifts use alu_b[SHCNT_WIDTH-1:0]
//  alu_funct      in   `ALU_FUNCT_WIDTH   operation code
//  alu_in_valid   in   1                  request valid
//  alu_in_ready   out  1                  request accepted when valid&ready
//  alu_result     out  ISA_WIDTH          registered result
//  alu_out_valid  out  1                  alu_result valid
//  alu_out_ready  in   1                  consumer takes result when valid&ready
// BEHAVIOUR
//  Reset: state=IDLE, alu_result=0, alu_out_valid=0; alu_in_ready=0 while rst=1.
//  States: IDLE -> (accept, non-shift or shamt=0) DONE; IDLE -> (accept, shift, shamt>0) BUSY;
//   BUSY: 1 bit shifted/cycle, counter decrements, at count 1 -> DONE; DONE: hold until out_ready.
//  alu_in_ready = IDLE | (DONE & alu_out_ready)  (back-to-back, one result/cycle for non-shifts).
//  Latency: non-shift result valid cycle after accept; iterative shift valid shamt cycles after accept.
//  Operands/funct latched on accept; input changes afterwards ignored.
//  ADD/SUB: modulo 2^ISA_WIDTH, no carry out. AND/OR/XOR bitwise.
//  EQ/NEQ/LESS_U/LESS_S: result = {zeros, 1-bit compare}; LESS_S two's complement.
//  SHIFT_L_L, SHIFT_R_L zero-fill; SHIFT_R_A replicates latched sign bit.
//  NO_FUNCT and any undefined code: result 0, one-cycle latency.
//  DONE with out_ready=0: alu_result and alu_out_valid held stable, alu_in_ready=0.
//  DONE & out_ready & in_valid same cycle: old result retires, new request accepted.
//  rst in BUSY/DONE: operation dropped, no alu_out_valid pulse afterwards.
//  alu_out_valid never depends combinationally on alu_out_ready.
// CONFIGURATION
//  ALU_FAST_SHIFT_EN defined: shifts use a barrel shifter, one-cycle latency like other ops;
//   BUSY state never entered.
//  Not defined: iterative 1-bit/cycle shifter as above (smaller area).
// STRUCTURE
//  config.vh: `ALU_FUNCT_WIDTH and all funct codes (ADD,SUB,EQ,NEQ,LESS_U,LESS_S,AND,OR,XOR,
//   SHIFT_L_L,SHIFT_R_L,SHIFT_R_A,NO_FUNCT); state encoding localparams stay in this file.
//  Sub-module alu_shifter: holds shift register + count, start/done interface; compiled
//   either as barrel or iterative per ALU_FAST_SHIFT_EN.
// TESTING
//  ADD a=0xFFFFFFFF b=1 -> alu_result=0x00000000, out_valid cycle after accept.
//  SUB a=0 b=1 -> 0xFFFFFFFF; LESS_U a=1 b=0xFFFFFFFF -> 1; LESS_S same -> 0.
//  SHIFT_R_A a=0x80000000 b=0x24 (shamt 4) -> 0xF8000000; 4 cycles iterative, 1 with ALU_FAST_SHIFT_EN.
//  Backpressure: ADD 2+3, out_ready low 3 cycles -> result 5 held, in_ready=0, then retires; next op accepted same cycle.
//  rst asserted during BUSY of SHIFT_L_L by 20 -> IDLE next cycle, out_valid stays 0, result 0.
//  NO_FUNCT a=0x1234 b=0x5678 -> 0; back-to-back 4 ADDs with out_ready=1 -> 4 results in 4 cycles.

Source files
------------

// File: rtl/exu_alu_seq_pkg.sv
// exu_alu_seq_pkg: ALU operation codes, shift kinds and small decode helpers
// shared by the sequential execution ALU, its shifter and its bus interface.
package exu_alu_seq_pkg;

  localparam int unsigned ALU_FUNCT_WIDTH = 4;

  // Operation codes carried on alu_funct; codes 13..15 are undefined.
  typedef enum logic [3:0] {
    ALU_NO_FUNCT  = 4'd0,
    ALU_ADD       = 4'd1,
    ALU_SUB       = 4'd2,
    ALU_EQ        = 4'd3,
    ALU_NEQ       = 4'd4,
    ALU_LESS_U    = 4'd5,
    ALU_LESS_S    = 4'd6,
    ALU_AND       = 4'd7,
    ALU_OR        = 4'd8,
    ALU_XOR       = 4'd9,
    ALU_SHIFT_L_L = 4'd10,
    ALU_SHIFT_R_L = 4'd11,
    ALU_SHIFT_R_A = 4'd12
  } alu_funct_e;

  // Direction/fill of a shift as seen by the shifter.
  typedef enum logic [1:0] {
    SH_LL = 2'd0,
    SH_RL = 2'd1,
    SH_RA = 2'd2
  } sh_kind_e;

  // True for the three shift operations.
  function automatic logic is_shift(input logic [ALU_FUNCT_WIDTH-1:0] funct);
    case (funct)
      ALU_SHIFT_L_L, ALU_SHIFT_R_L, ALU_SHIFT_R_A: is_shift = 1'b1;
      default:                                      is_shift = 1'b0;
    endcase
  endfunction

  // Map a shift opcode onto the shifter's kind encoding.
  function automatic sh_kind_e shift_kind(input logic [ALU_FUNCT_WIDTH-1:0] funct);
    case (funct)
      ALU_SHIFT_R_L: shift_kind = SH_RL;
      ALU_SHIFT_R_A: shift_kind = SH_RA;
      default:       shift_kind = SH_LL;
    endcase
  endfunction

endpackage

// File: rtl/exu_alu_seq_if.sv
// exu_alu_seq_if: request/response handshake bundle between the EXU operand
// selector (master) and the sequential ALU (slave).
interface exu_alu_seq_if #(
  parameter int unsigned ISA_WIDTH = 32
);
  import exu_alu_seq_pkg::*;

  logic [ISA_WIDTH-1:0]       alu_a;
  logic [ISA_WIDTH-1:0]       alu_b;
  logic [ALU_FUNCT_WIDTH-1:0] alu_funct;
  logic                       alu_in_valid;
  logic                       alu_in_ready;
  logic [ISA_WIDTH-1:0]       alu_result;
  logic                       alu_out_valid;
  logic                       alu_out_ready;

  modport master (
    output alu_a, alu_b, alu_funct, alu_in_valid, alu_out_ready,
    input  alu_in_ready, alu_result, alu_out_valid
  );

  modport slave (
    input  alu_a, alu_b, alu_funct, alu_in_valid, alu_out_ready,
    output alu_in_ready, alu_result, alu_out_valid
  );

endinterface

// File: rtl/exu_alu_seq_shifter.sv
// exu_alu_seq_shifter: shift unit of the sequential ALU.
// Build option ALU_FAST_SHIFT_EN: when defined, a combinational barrel shifter
// finishes every shift in the start cycle; otherwise an iterative shifter moves
// one bit per cycle. The first bit is already shifted in the start cycle, so a
// shift by n reports o_done n-1 cycles after start (shift by 0 or 1: at start).
// o_done/o_result are combinational; the top registers o_result when o_done.
module exu_alu_seq_shifter
  import exu_alu_seq_pkg::*;
#(
  parameter int unsigned ISA_WIDTH   = 32,
  parameter int unsigned SHCNT_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_start,
  input  sh_kind_e               i_kind,
  input  logic [ISA_WIDTH-1:0]   i_data,
  input  logic [SHCNT_WIDTH-1:0] i_shamt,
  output logic                   o_done,
  output logic [ISA_WIDTH-1:0]   o_result
);

`ifdef ALU_FAST_SHIFT_EN

  // Clock and reset are not needed by the purely combinational shifter.
  logic w_unused_clk_rst;
  assign w_unused_clk_rst = clk ^ rst;

  // Whole shift in one step; the result is ready in the start cycle.
  always_comb begin
    o_done = i_start;
    case (i_kind)
      SH_LL:   o_result = i_data << i_shamt;
      SH_RL:   o_result = i_data >> i_shamt;
      SH_RA:   o_result = ISA_WIDTH'($signed(i_data) >>> i_shamt);
      default: o_result = '0;
    endcase
  end

`else

  logic [ISA_WIDTH-1:0]   r_data;
  logic [SHCNT_WIDTH-1:0] r_cnt;
  sh_kind_e               r_kind;
  logic                   r_busy;
  logic [ISA_WIDTH-1:0]   w_src;
  logic [ISA_WIDTH-1:0]   w_step;
  sh_kind_e               w_kind;

  // Pick fresh operand on start, else the partial result, and shift it one bit.
  always_comb begin
    if (i_start) begin
      w_src  = i_data;
      w_kind = i_kind;
    end else begin
      w_src  = r_data;
      w_kind = r_kind;
    end
    case (w_kind)
      SH_LL:   w_step = {w_src[ISA_WIDTH-2:0], 1'b0};
      SH_RL:   w_step = {1'b0, w_src[ISA_WIDTH-1:1]};
      SH_RA:   w_step = {w_src[ISA_WIDTH-1], w_src[ISA_WIDTH-1:1]};
      default: w_step = w_src;
    endcase
  end

  // Report completion when the step about to be taken is the last one.
  always_comb begin
    if (i_start) begin
      o_done = (i_shamt <= SHCNT_WIDTH'(1));
      if (i_shamt == SHCNT_WIDTH'(0)) begin
        o_result = i_data;
      end else begin
        o_result = w_step;
      end
    end else begin
      o_done   = r_busy && (r_cnt == SHCNT_WIDTH'(1));
      o_result = w_step;
    end
  end

  // Partial result and remaining-step counter; reset abandons any shift.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data <= '0;
      r_cnt  <= '0;
      r_kind <= SH_LL;
      r_busy <= 1'b0;
    end else if (i_start) begin
      r_data <= w_step;
      r_cnt  <= i_shamt - SHCNT_WIDTH'(1);
      r_kind <= i_kind;
      r_busy <= (i_shamt > SHCNT_WIDTH'(1));
    end else if (r_busy) begin
      r_data <= w_step;
      r_cnt  <= r_cnt - SHCNT_WIDTH'(1);
      r_busy <= (r_cnt != SHCNT_WIDTH'(1));
    end
  end

`endif

endmodule

// File: rtl/exu_alu_seq.sv
// exu_alu_seq: execution ALU with valid/ready on request and result side.
// Non-shift ops (and undefined codes, which yield 0) produce a registered
// result the cycle after accept; shifts go through exu_alu_seq_shifter.
// Build option ALU_FAST_SHIFT_EN selects the one-cycle barrel shifter, in which
// case the BUSY state is never entered.
module exu_alu_seq
  import exu_alu_seq_pkg::*;
#(
  parameter int unsigned ISA_WIDTH   = 32,
  parameter int unsigned SHCNT_WIDTH = $clog2(ISA_WIDTH)
) (
  input  logic          clk,
  input  logic          rst,
  exu_alu_seq_if.slave  alu_bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e                 r_state;
  state_e                 w_state_nxt;
  state_e                 w_launch_state;
  logic                   w_in_ready;
  logic                   w_accept;
  logic                   w_is_shift;
  logic                   w_sh_start;
  logic                   w_sh_done;
  logic [SHCNT_WIDTH-1:0] w_shamt;
  logic [ISA_WIDTH-1:0]   w_sh_result;
  logic [ISA_WIDTH-1:0]   w_op_result;
  logic [ISA_WIDTH-1:0]   r_result;
  logic                   r_out_valid;

  assign w_is_shift = is_shift(alu_bus.alu_funct);
  assign w_shamt    = alu_bus.alu_b[SHCNT_WIDTH-1:0];

  exu_alu_seq_shifter #(
    .ISA_WIDTH   (ISA_WIDTH),
    .SHCNT_WIDTH (SHCNT_WIDTH)
  ) u_shifter (
    .clk      (clk),
    .rst      (rst),
    .i_start  (w_sh_start),
    .i_kind   (shift_kind(alu_bus.alu_funct)),
    .i_data   (alu_bus.alu_a),
    .i_shamt  (w_shamt),
    .o_done   (w_sh_done),
    .o_result (w_sh_result)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: a new request goes to DONE unless the shifter still needs cycles.
  always_comb begin
    if (!w_is_shift || w_sh_done) begin
      w_launch_state = ST_DONE;
    end else begin
      w_launch_state = ST_BUSY;
    end
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = w_launch_state;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (w_sh_done) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_BUSY;
        end
      end
      ST_DONE: begin
        if (w_accept) begin
          w_state_nxt = w_launch_state;
        end else if (alu_bus.alu_out_ready) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_DONE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Handshake outputs: accept when idle, or when the held result retires this cycle.
  always_comb begin
    w_in_ready = !rst && ((r_state == ST_IDLE) ||
                          ((r_state == ST_DONE) && alu_bus.alu_out_ready));
    w_accept   = w_in_ready && alu_bus.alu_in_valid;
    w_sh_start = w_accept && w_is_shift;
  end

  // Single-cycle operations; shifts and undefined codes give 0 here.
  always_comb begin
    case (alu_bus.alu_funct)
      ALU_ADD:    w_op_result = alu_bus.alu_a + alu_bus.alu_b;
      ALU_SUB:    w_op_result = alu_bus.alu_a - alu_bus.alu_b;
      ALU_EQ:     w_op_result = {{(ISA_WIDTH-1){1'b0}}, (alu_bus.alu_a == alu_bus.alu_b)};
      ALU_NEQ:    w_op_result = {{(ISA_WIDTH-1){1'b0}}, (alu_bus.alu_a != alu_bus.alu_b)};
      ALU_LESS_U: w_op_result = {{(ISA_WIDTH-1){1'b0}}, (alu_bus.alu_a < alu_bus.alu_b)};
      ALU_LESS_S: w_op_result = {{(ISA_WIDTH-1){1'b0}},
                                 ($signed(alu_bus.alu_a) < $signed(alu_bus.alu_b))};
      ALU_AND:    w_op_result = alu_bus.alu_a & alu_bus.alu_b;
      ALU_OR:     w_op_result = alu_bus.alu_a | alu_bus.alu_b;
      ALU_XOR:    w_op_result = alu_bus.alu_a ^ alu_bus.alu_b;
      default:    w_op_result = '0;
    endcase
  end

  // Result register and its valid flag; both cleared by reset, held under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_result    <= '0;
      r_out_valid <= 1'b0;
    end else if (w_accept && (!w_is_shift || w_sh_done)) begin
      r_result    <= w_is_shift ? w_sh_result : w_op_result;
      r_out_valid <= 1'b1;
    end else if ((r_state == ST_BUSY) && w_sh_done) begin
      r_result    <= w_sh_result;
      r_out_valid <= 1'b1;
    end else if ((r_state == ST_DONE) && alu_bus.alu_out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign alu_bus.alu_in_ready  = w_in_ready;
  assign alu_bus.alu_result    = r_result;
  assign alu_bus.alu_out_valid = r_out_valid;

endmodule

// File: tb/tb_exu_alu_seq.sv
// tb_exu_alu_seq: directed corner cases plus randomized operations checked
// against an arithmetic reference model of the ALU.
module tb_exu_alu_seq;
  import exu_alu_seq_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  exu_alu_seq_if #(.ISA_WIDTH(32)) bus ();

  exu_alu_seq #(.ISA_WIDTH(32), .SHCNT_WIDTH(5)) dut (
    .clk     (clk),
    .rst     (rst),
    .alu_bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Reference behaviour written directly from the operation definitions.
  function automatic logic [31:0] ref_alu(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    int sh;
    sa = a;
    sb = b;
    sh = int'(b[4:0]);
    case (f)
      4'd1:  return a + b;
      4'd2:  return a - b;
      4'd3:  return (a == b) ? 32'd1 : 32'd0;
      4'd4:  return (a != b) ? 32'd1 : 32'd0;
      4'd5:  return (a < b) ? 32'd1 : 32'd0;
      4'd6:  return (sa < sb) ? 32'd1 : 32'd0;
      4'd7:  return a & b;
      4'd8:  return a | b;
      4'd9:  return a ^ b;
      4'd10: return a << sh;
      4'd11: return a >> sh;
      4'd12: return 32'(sa >>> sh);
      default: return 32'd0;
    endcase
  endfunction

  // Cycles from accept to the first cycle the result is visible.
  function automatic int exp_lat(input logic [3:0] f, input logic [31:0] b);
`ifdef ALU_FAST_SHIFT_EN
    if (f == 4'd15 && b == 32'd0) return 1;
    return 1;
`else
    if (f >= 4'd10 && f <= 4'd12 && b[4:0] != 5'd0) return int'(b[4:0]);
    return 1;
`endif
  endfunction

  task automatic run_op(input string tag, input logic [3:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    int guard;
    int lat;
    @(negedge clk);
    bus.alu_funct = f; bus.alu_a = a; bus.alu_b = b;
    bus.alu_in_valid = 1'b1; bus.alu_out_ready = 1'b1;
    guard = 0;
    while (!bus.alu_in_ready && guard < 100) begin @(negedge clk); guard++; end
    check_eq({tag, "_inrdy"}, 32'(bus.alu_in_ready), 32'd1);
    @(posedge clk); #1;
    bus.alu_in_valid = 1'b0;
    bus.alu_a = $urandom; bus.alu_b = $urandom; bus.alu_funct = 4'($urandom);
    lat = 0;
    do begin @(negedge clk); lat++; end while (!bus.alu_out_valid && lat < 100);
    check_eq({tag, "_res"}, bus.alu_result, exp);
    check_eq({tag, "_lat"}, 32'(lat), 32'(exp_lat(f, b)));
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 3))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] q_exp [4];
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  f;
    logic        seen_valid;

    bus.alu_a = 32'd0; bus.alu_b = 32'd0; bus.alu_funct = 4'd0;
    bus.alu_in_valid = 1'b0; bus.alu_out_ready = 1'b1;

    // Reset state.
    repeat (3) @(negedge clk);
    bus.alu_in_valid = 1'b1;
    #1;
    check_eq("rst_out_valid", 32'(bus.alu_out_valid), 32'd0);
    check_eq("rst_result", bus.alu_result, 32'd0);
    check_eq("rst_in_ready", 32'(bus.alu_in_ready), 32'd0);
    bus.alu_in_valid = 1'b0;
    rst = 1'b0;
    #1;
    check_eq("idle_in_ready", 32'(bus.alu_in_ready), 32'd1);

    // Directed corner cases.
    run_op("add_wrap", 4'd1, 32'hFFFF_FFFF, 32'h1, 32'h0000_0000);
    run_op("sub_wrap", 4'd2, 32'h0, 32'h1, 32'hFFFF_FFFF);
    run_op("less_u", 4'd5, 32'h1, 32'hFFFF_FFFF, 32'h1);
    run_op("less_s", 4'd6, 32'h1, 32'hFFFF_FFFF, 32'h0);
    run_op("sra4", 4'd12, 32'h8000_0000, 32'h24, 32'hF800_0000);
    run_op("no_funct", 4'd0, 32'h1234, 32'h5678, 32'h0);
    run_op("undef", 4'd14, 32'hDEAD_BEEF, 32'h1, 32'h0);
    run_op("sll0", 4'd10, 32'hA5A5_0001, 32'h20, 32'hA5A5_0001);
    run_op("srl1", 4'd11, 32'h8000_0001, 32'h1, 32'h4000_0000);

    // Backpressure: result held while the consumer stalls, then retire + accept together.
    @(negedge clk);
    bus.alu_funct = 4'd1; bus.alu_a = 32'd2; bus.alu_b = 32'd3;
    bus.alu_in_valid = 1'b1; bus.alu_out_ready = 1'b0;
    @(posedge clk); #1;
    bus.alu_a = 32'd7; bus.alu_b = 32'd8;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("bp_valid", 32'(bus.alu_out_valid), 32'd1);
      check_eq("bp_hold", bus.alu_result, 32'd5);
      check_eq("bp_in_ready", 32'(bus.alu_in_ready), 32'd0);
    end
    bus.alu_out_ready = 1'b1;
    #1;
    check_eq("bp_release_ready", 32'(bus.alu_in_ready), 32'd1);
    @(posedge clk); #1;
    bus.alu_in_valid = 1'b0;
    @(negedge clk);
    check_eq("bp_next_valid", 32'(bus.alu_out_valid), 32'd1);
    check_eq("bp_next_res", bus.alu_result, 32'd15);

    // Back-to-back ADDs: one result per cycle.
    @(negedge clk);
    for (int k = 0; k <= 4; k++) begin
      if (k > 0) begin
        check_eq("b2b_valid", 32'(bus.alu_out_valid), 32'd1);
        check_eq("b2b_res", bus.alu_result, q_exp[k-1]);
      end
      if (k < 4) begin
        a = $urandom; b = $urandom;
        bus.alu_funct = 4'd1; bus.alu_a = a; bus.alu_b = b; bus.alu_in_valid = 1'b1;
        q_exp[k] = a + b;
        #1;
        check_eq("b2b_in_ready", 32'(bus.alu_in_ready), 32'd1);
      end else begin
        bus.alu_in_valid = 1'b0;
      end
      @(negedge clk);
    end

    // Reset while a shift by 20 is in flight: the operation is dropped.
    @(negedge clk);
    bus.alu_funct = 4'd10; bus.alu_a = 32'h0000_0001; bus.alu_b = 32'd20;
    bus.alu_in_valid = 1'b1; bus.alu_out_ready = 1'b0;
    @(posedge clk); #1;
    bus.alu_in_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("rst_busy_in_ready", 32'(bus.alu_in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.alu_out_ready = 1'b1;
    #1;
    check_eq("rst_busy_idle", 32'(bus.alu_in_ready), 32'd1);
    seen_valid = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      seen_valid = seen_valid | bus.alu_out_valid;
    end
    check_eq("rst_busy_no_valid", 32'(seen_valid), 32'd0);
    check_eq("rst_busy_result", bus.alu_result, 32'd0);

    // Randomized operations against the reference model.
    for (int n = 0; n < 40; n++) begin
      f = 4'($urandom_range(0, 15));
      a = pick_operand();
      b = ($urandom_range(0, 3) == 0) ? a : pick_operand();
      run_op("rand", f, a, b, ref_alu(f, a, b));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
